// File: rtl/iob_spi_master_lane_pkg.sv
// Shared types and lane-mode helpers for the SPI lane engine.
package iob_spi_master_lane_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DUMMY,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE,
        ST_RELEASE
    } state_t;

    // Encoding doubles as log2(lanes), so it is used directly as a shift amount
    localparam logic [1:0] LANES_SINGLE = 2'd0;
    localparam logic [1:0] LANES_DUAL   = 2'd1;
    localparam logic [1:0] LANES_QUAD   = 2'd2;

    function automatic logic [1:0] lane_mode(input logic [1:0] lanes);
        return (lanes == LANES_DUAL || lanes == LANES_QUAD) ? lanes : LANES_SINGLE;
    endfunction

    function automatic logic [1:0] lane_mask(input logic [1:0] mode);
        case (mode)
            LANES_DUAL: return 2'd1;
            LANES_QUAD: return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/iob_spi_master_lane_clkgen.sv
// SCLK generator: half-period divider emitting leading/trailing edge strobes.
module iob_spi_master_lane_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             cpol_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             lead_edge_o,
    output logic             trail_edge_o,
    output logic             sclk_o
);

    logic [DIV_W-1:0] cnt_q;
    logic             phase_q;
    logic             tick;

    assign tick         = en_i && (cnt_q == div_i);
    assign lead_edge_o  = tick && !phase_q;
    assign trail_edge_o = tick && phase_q;
    assign sclk_o       = cpol_i ^ (en_i & phase_q);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !en_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/iob_spi_master_lane_engine.sv
// SPI shift engine: 1/2/4 lanes, CPOL/CPHA, dummy cycles, SS chaining across commands.
module iob_spi_master_lane_engine
    import iob_spi_master_lane_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NSS     = 4,
    parameter int DIV_W   = 8,
    parameter int DUMMY_W = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [$clog2(DATA_W+1)-1:0] cmd_nbits_i,
    input  logic                      cmd_dir_i,
    input  logic [1:0]                cmd_lanes_i,
    input  logic [DUMMY_W-1:0]        cmd_dummy_i,
    input  logic [$clog2(NSS)-1:0]    cmd_ss_sel_i,
    input  logic                      cmd_hold_ss_i,
    input  logic [DATA_W-1:0]         cmd_tx_data_i,
    input  logic [DIV_W-1:0]          div_i,
    input  logic                      cpol_i,
    input  logic                      cpha_i,
    output logic                      rx_valid_o,
    output logic [DATA_W-1:0]         rx_data_o,
    output logic                      busy_o,
    output logic                      sclk_o,
    output logic [NSS-1:0]            ss_n_o,
    output logic [3:0]                dq_o,
    output logic [3:0]                dq_oe_o,
    input  logic [3:0]                dq_i
);

    localparam int NB_W  = $clog2(DATA_W+1);
    localparam int SS_W  = $clog2(NSS);
    localparam int CYC_W = (NB_W > DUMMY_W) ? NB_W : DUMMY_W;

    state_t             state_q, state_d;
    logic               ready_q, ss_held_q;
    logic [NB_W-1:0]    nbits_q, ncyc_q;
    logic               dir_q, hold_q, cpol_q, cpha_q;
    logic [1:0]         mode_q, pad_q;
    logic [DUMMY_W-1:0] dummy_q;
    logic [SS_W-1:0]    sel_q;
    logic [DIV_W-1:0]   div_q, wait_q;
    logic [CYC_W-1:0]   cyc_q;
    logic [DATA_W-1:0]  tx_sr_q, rx_sr_q, rx_data_q, ones, tx_mask;

    logic               accept, wait_done, clk_en, lead_edge, trail_edge;
    logic               sample_edge, launch_edge, eff_hold;
    logic [1:0]         in_mode, in_pad;
    logic [NB_W:0]      in_sum;
    logic [NB_W-1:0]    in_ncyc, eff_ncyc;
    logic [DUMMY_W-1:0] eff_dummy;

    assign accept    = cmd_valid_i && ready_q;
    assign wait_done = (wait_q == div_q);
    assign clk_en    = (state_q == ST_DUMMY) || (state_q == ST_SHIFT);

    // Data cycles = ceil(nbits/L); pad = bits sampled past nbits in the last cycle
    assign in_mode = lane_mode(cmd_lanes_i);
    assign in_sum  = {1'b0, cmd_nbits_i} + (NB_W+1)'(lane_mask(in_mode));
    assign in_ncyc = NB_W'(in_sum >> in_mode);
    assign in_pad  = (~cmd_nbits_i[1:0] + 2'd1) & lane_mask(in_mode);
    assign ones    = '1;
    assign tx_mask = ~(ones >> cmd_nbits_i);

    // Values needed on the same edge as accept, before the latches are valid
    assign eff_dummy = (state_q == ST_IDLE) ? cmd_dummy_i   : dummy_q;
    assign eff_ncyc  = (state_q == ST_IDLE) ? in_ncyc       : ncyc_q;
    assign eff_hold  = (state_q == ST_IDLE) ? cmd_hold_ss_i : hold_q;

    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign launch_edge = cpha_q ? (lead_edge && cyc_q != CYC_W'(ncyc_q)) : trail_edge;

    iob_spi_master_lane_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (clk_en),
        .cpol_i       (cpol_q),
        .div_i        (div_q),
        .lead_edge_o  (lead_edge),
        .trail_edge_o (trail_edge),
        .sclk_o       (sclk_o)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ss_held_q && cmd_ss_sel_i == sel_q) begin
                        if (cmd_dummy_i != '0)   state_d = ST_DUMMY;
                        else if (in_ncyc != '0)  state_d = ST_SHIFT;
                        else                     state_d = ST_DONE;
                    end else if (ss_held_q) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_RELEASE: if (wait_done) state_d = ST_SETUP;
            ST_SETUP: begin
                if (wait_done) begin
                    if (dummy_q != '0)      state_d = ST_DUMMY;
                    else if (ncyc_q != '0)  state_d = ST_SHIFT;
                    else                    state_d = ST_HOLD;
                end
            end
            ST_DUMMY: begin
                if (trail_edge && cyc_q == CYC_W'(1))
                    state_d = (ncyc_q != '0) ? ST_SHIFT : ST_HOLD;
            end
            ST_SHIFT: if (trail_edge && cyc_q == CYC_W'(1)) state_d = ST_HOLD;
            ST_HOLD:  if (hold_q || wait_done) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            ss_held_q <= 1'b0;
            nbits_q   <= '0;
            ncyc_q    <= '0;
            dir_q     <= 1'b0;
            hold_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            mode_q    <= LANES_SINGLE;
            pad_q     <= '0;
            dummy_q   <= '0;
            sel_q     <= '0;
            div_q     <= '0;
            wait_q    <= '0;
            cyc_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            wait_q  <= (state_d != state_q) ? '0 : wait_q + DIV_W'(1);

            if (accept) begin
                nbits_q <= cmd_nbits_i;
                ncyc_q  <= in_ncyc;
                pad_q   <= in_pad;
                dir_q   <= cmd_dir_i;
                mode_q  <= in_mode;
                dummy_q <= cmd_dummy_i;
                sel_q   <= cmd_ss_sel_i;
                hold_q  <= cmd_hold_ss_i;
                div_q   <= div_i;
                cpol_q  <= cpol_i;
                cpha_q  <= cpha_i;
                tx_sr_q <= cmd_tx_data_i & tx_mask;
                rx_sr_q <= '0;
            end

            if (state_d != state_q) begin
                if (state_d == ST_DUMMY)      cyc_q <= CYC_W'(eff_dummy);
                else if (state_d == ST_SHIFT) cyc_q <= CYC_W'(eff_ncyc);
            end else if (trail_edge) begin
                cyc_q <= cyc_q - CYC_W'(1);
            end

            if (state_q == ST_SHIFT) begin
                if (sample_edge) begin
                    case (mode_q)
                        LANES_QUAD: rx_sr_q <= {rx_sr_q[DATA_W-5:0], dq_i};
                        LANES_DUAL: rx_sr_q <= {rx_sr_q[DATA_W-3:0], dq_i[1:0]};
                        default:    rx_sr_q <= {rx_sr_q[DATA_W-2:0], dq_i[1]};
                    endcase
                end
                if (launch_edge) begin
                    case (mode_q)
                        LANES_QUAD: tx_sr_q <= {tx_sr_q[DATA_W-5:0], 4'b0000};
                        LANES_DUAL: tx_sr_q <= {tx_sr_q[DATA_W-3:0], 2'b00};
                        default:    tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                    endcase
                end
            end

            if (state_d == ST_RELEASE) ss_held_q <= 1'b0;
            if (state_d == ST_DONE && state_q != ST_DONE) begin
                ss_held_q <= eff_hold;
                if (dir_q && nbits_q != '0) rx_data_q <= rx_sr_q >> pad_q;
            end
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign rx_valid_o  = (state_q == ST_DONE) && dir_q && (nbits_q != '0);
    assign rx_data_o   = rx_data_q;

    always_comb begin
        ss_n_o = '1;
        if (state_q == ST_SETUP || state_q == ST_DUMMY ||
            state_q == ST_SHIFT || state_q == ST_HOLD)
            ss_n_o[sel_q] = 1'b0;
        else if ((state_q == ST_IDLE || state_q == ST_DONE) && ss_held_q)
            ss_n_o[sel_q] = 1'b0;
    end

    always_comb begin
        dq_o    = 4'b1100;
        dq_oe_o = 4'b1100;
        if (state_q != ST_IDLE) begin
            case (mode_q)
                LANES_QUAD: begin
                    dq_o    = tx_sr_q[DATA_W-1 -: 4];
                    dq_oe_o = (!dir_q && state_q != ST_DUMMY) ? 4'b1111 : 4'b0000;
                end
                LANES_DUAL: begin
                    dq_o    = {2'b11, tx_sr_q[DATA_W-1 -: 2]};
                    dq_oe_o = (!dir_q && state_q != ST_DUMMY) ? 4'b1111 : 4'b1100;
                end
                default: begin
                    dq_o    = {3'b110, tx_sr_q[DATA_W-1]};
                    dq_oe_o = 4'b1101;
                end
            endcase
        end
    end

endmodule
